// File: rtl/fsm_deco_seq.sv
// fsm_deco_seq: sequenced instruction decoder with valid/ready intake and req/ack memory access.
// Define DECO_TIMEOUT_EN to enable the memory-wait timeout and the sticky mem_err flag.
module fsm_deco_seq #(
  parameter int RA_W    = 2,
  parameter int TIMEOUT = 16,
  localparam int INSTR_W = 4 + 2 * RA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         alu_op,
  output logic [RA_W-1:0]    rd_addr1,
  output logic [RA_W-1:0]    rd_addr2,
  output logic [RA_W-1:0]    wrt_addr,
  output logic               wrt_en,
  output logic               load_data,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ack,
  input  logic               resume,
  output logic               halted,
  output logic               illegal,
  output logic               mem_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t            state_r;
  logic [3:0]        op_s;
  logic [RA_W-1:0]   opr1_s;
  logic [RA_W-1:0]   opr2_s;
  logic              timeout_s;

  assign op_s        = instr[INSTR_W-1 -: 4];
  assign opr1_s      = instr[2*RA_W-1 -: RA_W];
  assign opr2_s      = instr[RA_W-1:0];
  assign instr_ready = (state_r == IDLE);
  assign halted      = (state_r == HALT);

`ifdef DECO_TIMEOUT_EN
  logic [7:0] cnt_r;
  logic       mem_err_r;

  assign timeout_s = (cnt_r == 8'(TIMEOUT - 1));
  assign mem_err   = mem_err_r;

  // Memory-wait counter, restarted on every accepted instruction; sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 8'd0;
      mem_err_r <= 1'b0;
    end else begin
      if (instr_valid && (state_r == IDLE)) begin
        cnt_r <= 8'd0;
      end else if (state_r == MEM) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if ((state_r == MEM) && !mem_ack && timeout_s) begin
        mem_err_r <= 1'b1;
      end
    end
  end
`else
  logic [7:0] unused_timeout_s;

  assign unused_timeout_s = 8'(TIMEOUT);
  assign timeout_s        = 1'b0;
  assign mem_err          = 1'b0;
`endif

  // Main sequencer: state, latched decode fields and handshake strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      alu_op    <= 4'd0;
      rd_addr1  <= '0;
      rd_addr2  <= '0;
      wrt_addr  <= '0;
      wrt_en    <= 1'b0;
      load_data <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Address outputs are already zero here, so only the used fields are loaded
          if (instr_valid) begin
            alu_op <= op_s;
            case (op_s)
              4'd0: state_r <= EXEC;
              4'd1: begin
                state_r  <= EXEC;
                wrt_addr <= opr1_s;
                wrt_en   <= 1'b1;
              end
              4'd2, 4'd3: begin
                state_r  <= EXEC;
                rd_addr1 <= opr1_s;
                wrt_addr <= opr1_s;
                wrt_en   <= 1'b1;
              end
              4'd4: begin
                state_r   <= MEM;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                wrt_addr  <= opr1_s;
                load_data <= 1'b1;
              end
              4'd5: begin
                state_r  <= MEM;
                mem_req  <= 1'b1;
                mem_we   <= 1'b1;
                rd_addr1 <= opr1_s;
              end
              4'd6, 4'd8: begin
                state_r  <= EXEC;
                rd_addr1 <= opr1_s;
                rd_addr2 <= opr2_s;
                wrt_addr <= opr1_s;
                wrt_en   <= 1'b1;
              end
              4'd7: begin
                state_r  <= EXEC;
                rd_addr1 <= opr2_s;
                wrt_addr <= opr1_s;
                wrt_en   <= 1'b1;
              end
              4'd9: state_r <= HALT;
              default: begin
                state_r <= EXEC;
                illegal <= 1'b1;
              end
            endcase
          end
        end
        EXEC, WB: begin
          state_r   <= IDLE;
          wrt_en    <= 1'b0;
          load_data <= 1'b0;
          rd_addr1  <= '0;
          rd_addr2  <= '0;
          wrt_addr  <= '0;
        end
        MEM: begin
          // An ack on the limit edge takes priority over the timeout
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_we) begin
              state_r  <= IDLE;
              rd_addr1 <= '0;
            end else begin
              state_r <= WB;
              wrt_en  <= 1'b1;
            end
          end else if (timeout_s) begin
            state_r   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            load_data <= 1'b0;
            rd_addr1  <= '0;
            wrt_addr  <= '0;
          end
        end
        HALT: begin
          if (resume) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          wrt_en    <= 1'b0;
          load_data <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          rd_addr1  <= '0;
          rd_addr2  <= '0;
          wrt_addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_deco_seq.sv
// Randomized scoreboard bench for fsm_deco_seq: expected writes and memory requests are queued
// at issue time from an opcode-level model and popped by an independent monitor.
`define CHK(n, a, e) chk(n, 32'(a), 32'(e))

module tb_fsm_deco_seq;
  localparam int RA_W = 2;
`ifdef DECO_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       mem_ack = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] instr = 8'd0;
  logic       instr_ready, wrt_en, load_data, mem_req, mem_we, halted, illegal, mem_err;
  logic [3:0] alu_op;
  logic [1:0] rd_addr1, rd_addr2, wrt_addr;

  int checks = 0;
  int errors = 0;
  bit exp_illegal = 1'b0;
  bit exp_mem_err = 1'b0;

  typedef struct packed {logic [3:0] op; logic [1:0] wa; logic [1:0] r1; logic [1:0] r2; logic ld;} wr_t;
  typedef struct packed {logic we; logic [1:0] wa; logic [1:0] r1; logic ld;} mr_t;
  wr_t wq[$];
  mr_t mq[$];

  fsm_deco_seq #(.RA_W(RA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wrt_addr(wrt_addr), .wrt_en(wrt_en), .load_data(load_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_ack(mem_ack), .resume(resume), .halted(halted),
    .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode-level reference: which register write and memory request an instruction causes
  function automatic void model(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                                output bit wr, output wr_t w, output bit mr, output mr_t m);
    wr = 1'b0; mr = 1'b0; w = '0; m = '0; w.op = op;
    case (op)
      4'd1: begin wr = 1'b1; w.wa = a; end
      4'd2, 4'd3: begin wr = 1'b1; w.wa = a; w.r1 = a; end
      4'd4: begin wr = 1'b1; w.wa = a; w.ld = 1'b1; mr = 1'b1; m.wa = a; m.ld = 1'b1; end
      4'd5: begin mr = 1'b1; m.we = 1'b1; m.r1 = a; end
      4'd6, 4'd8: begin wr = 1'b1; w.wa = a; w.r1 = a; w.r2 = b; end
      4'd7: begin wr = 1'b1; w.wa = a; w.r1 = b; end
      default: ;
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT strobes a write or raises a memory request
  initial begin
    logic prev_req, prev_wen;
    wr_t e;
    mr_t m;
    prev_req = 1'b0;
    prev_wen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_wen = 1'b0;
      end else begin
        if (wrt_en) begin
          `CHK("wrt_en_pulse", prev_wen, 1'b0);
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got wrt_en=1 wrt_addr=%0d alu_op=%0d expected no write", wrt_addr, alu_op);
          end else begin
            e = wq.pop_front();
            `CHK("wr_alu_op", alu_op, e.op);
            `CHK("wr_wrt_addr", wrt_addr, e.wa);
            `CHK("wr_rd_addr1", rd_addr1, e.r1);
            `CHK("wr_rd_addr2", rd_addr2, e.r2);
            `CHK("wr_load_data", load_data, e.ld);
          end
        end
        if (mem_req && !prev_req) begin
          if (mq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: got mem_req=1 mem_we=%0d expected no request", mem_we);
          end else begin
            m = mq.pop_front();
            `CHK("mr_mem_we", mem_we, m.we);
            `CHK("mr_wrt_addr", wrt_addr, m.wa);
            `CHK("mr_rd_addr1", rd_addr1, m.r1);
            `CHK("mr_rd_addr2", rd_addr2, 2'd0);
            `CHK("mr_load_data", load_data, m.ld);
          end
        end
        prev_req = mem_req;
        prev_wen = wrt_en;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    `CHK("ready_wait", instr_ready, 1'b1);
  endtask

  // Issues one instruction at a negedge; returns at the negedge where instr_ready is back
  task automatic issue(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b, input int d);
    bit wr, mr;
    wr_t w;
    mr_t m;
    wait_ready();
    model(op, a, b, wr, w, mr, m);
    if (wr) wq.push_back(w);
    if (mr) mq.push_back(m);
    if (op >= 4'd10) exp_illegal = 1'b1;
    instr = {op, a, b};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 8'($urandom);
    if (op == 4'd4 || op == 4'd5) begin
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        `CHK("mem_req_held", mem_req, 1'b1);
        if (k == d) mem_ack = 1'b1;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (op == 4'd4) begin
        @(negedge clk);
        `CHK("load_wb_not_ready", instr_ready, 1'b0);
        `CHK("load_req_drop", mem_req, 1'b0);
      end
      @(negedge clk);
      `CHK("mem_ready_return", instr_ready, 1'b1);
      `CHK("mem_req_idle", mem_req, 1'b0);
    end else if (op == 4'd9) begin
      @(negedge clk);
      `CHK("halt_halted", halted, 1'b1);
      `CHK("halt_not_ready", instr_ready, 1'b0);
      instr = {4'd7, 2'd0, 2'd1};
      instr_valid = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        `CHK("halt_holds_off", instr_ready, 1'b0);
      end
      resume = 1'b1;
      @(posedge clk); #1;
      resume = 1'b0;
      instr_valid = 1'b0;
      @(negedge clk);
      `CHK("resume_halted", halted, 1'b0);
      `CHK("resume_ready", instr_ready, 1'b1);
    end else begin
      @(negedge clk);
      `CHK("exec_not_ready", instr_ready, 1'b0);
      mem_ack = 1'($urandom);
      resume = 1'($urandom);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      resume = 1'b0;
      @(negedge clk);
      `CHK("exec_ready_return", instr_ready, 1'b1);
    end
    `CHK("idle_addr_clear", {wrt_addr, rd_addr1, rd_addr2, load_data}, 7'd0);
    `CHK("illegal_flag", illegal, exp_illegal);
    `CHK("mem_err_flag", mem_err, exp_mem_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    wq.delete();
    mq.delete();
    exp_illegal = 1'b0;
    exp_mem_err = 1'b0;
    `CHK("rst_outputs", {alu_op, rd_addr1, rd_addr2, wrt_addr, wrt_en, load_data, mem_req,
                         mem_we, halted, illegal, mem_err}, 17'd0);
    `CHK("rst_ready", instr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reset_mid_mem();
    mr_t m;
    wait_ready();
    m = '0; m.wa = 2'd3; m.ld = 1'b1;
    mq.push_back(m);
    wq.push_back(wr_t'{op: 4'd4, wa: 2'd3, r1: 2'd0, r2: 2'd0, ld: 1'b1});
    instr = {4'd4, 2'd3, 2'd0};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    `CHK("midmem_req", mem_req, 1'b1);
    @(negedge clk);
    do_reset();
  endtask

`ifdef DECO_TIMEOUT_EN
  task automatic timeout_load(input logic [1:0] a);
    mr_t m;
    wait_ready();
    m = '0; m.wa = a; m.ld = 1'b1;
    mq.push_back(m);
    instr = {4'd4, a, 2'd0};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      `CHK("tmo_req_held", mem_req, 1'b1);
    end
    @(negedge clk);
    exp_mem_err = 1'b1;
    `CHK("tmo_req_drop", mem_req, 1'b0);
    `CHK("tmo_mem_err", mem_err, 1'b1);
    `CHK("tmo_ready", instr_ready, 1'b1);
    `CHK("tmo_no_load_data", load_data, 1'b0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    `CHK("reset_outputs", {alu_op, rd_addr1, rd_addr2, wrt_addr, wrt_en, load_data, mem_req,
                           mem_we, halted, illegal, mem_err}, 17'd0);
    `CHK("reset_ready", instr_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd6, 2'd1, 2'd2, 0);
    issue(4'd4, 2'd3, 2'd0, 3);
    issue(4'd5, 2'd2, 2'd0, 0);
    issue(4'd9, 2'd0, 2'd0, 0);
    issue(4'd7, 2'd0, 2'd1, 0);
    issue(4'd12, 2'd1, 2'd1, 0);
    repeat (10) issue(4'd0, 2'($urandom), 2'($urandom), 0);
    `CHK("illegal_after_noops", illegal, 1'b1);
    @(negedge clk);
    do_reset();
    `CHK("illegal_cleared", illegal, 1'b0);

    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    end

`ifdef DECO_TIMEOUT_EN
    timeout_load(2'd1);
    issue(4'd4, 2'd2, 2'd0, TMO - 1);
`endif
    reset_mid_mem();
    issue(4'd2, 2'd1, 2'd0, 0);
    repeat (2) @(negedge clk);
    `CHK("wq_drained", wq.size(), 0);
    `CHK("mq_drained", mq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_deco_seq.md
# fsm_deco_seq

Sequenced instruction decoder for the Fibonacci datapath, and the successor to the combinational opcode decoder. It accepts instructions over a valid/ready handshake and decodes them into registered register-file and ALU controls. Load and store are multi-cycle, using a request/acknowledge memory handshake. It adds `sub` and `halt` opcodes, illegal-opcode reporting and a register-address width set by parameter.

## Interface
- `RA_W`, default 2: register address width; the register file holds 2^RA_W entries.
- `TIMEOUT`, default 16: memory-wait limit in cycles, used only when `DECO_TIMEOUT_EN` is defined. Legal range is 2..255.
- `INSTR_W`, derived, not overridable: 4 + 2*RA_W. The instruction is `{op[3:0], opr1[RA_W-1:0], opr2[RA_W-1:0]}`.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: an instruction is offered.
- `instr_ready` out 1: the block can accept; equals (state == IDLE).
- `instr` in INSTR_W: the instruction word.
- `alu_op` out 4: latched opcode.
- `rd_addr1`, `rd_addr2` out RA_W: register-file read addresses.
- `wrt_addr` out RA_W: register-file write address.
- `wrt_en` out 1: write strobe, single-cycle pulse.
- `load_data` out 1: write-data mux selects memory data.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: 1 for store, 0 for load; meaningful only while `mem_req` is high.
- `mem_ack` in 1: memory acknowledge, sampled while `mem_req` is high.
- `resume` in 1: leave the HALT state.
- `halted` out 1: high while in HALT.
- `illegal` out 1: sticky; an opcode of 10..15 was accepted.
- `mem_err` out 1: sticky memory-timeout flag.

## Operation
States are IDLE, EXEC, MEM, WB and HALT. The handshake fires when `instr_valid` and `instr_ready` are both high at a rising edge.

Fields latched on accept: `alu_op` = op. All address outputs are 0 except as listed below.

Non-memory opcodes go from IDLE to EXEC for one cycle, then back to IDLE:
- 0 noop: no write.
- 1 set: `wrt_addr`=opr1, `wrt_en`.
- 2 inc and 3 dec: `rd_addr1`=`wrt_addr`=opr1, `wrt_en`.
- 6 add and 8 sub: `rd_addr1`=opr1, `rd_addr2`=opr2, `wrt_addr`=opr1, `wrt_en`.
- 7 copy: `rd_addr1`=opr2, `wrt_addr`=opr1, `wrt_en`.

Memory opcodes:
- 4 load: IDLE → MEM with `mem_req`=1, `mem_we`=0, `wrt_addr`=opr1, `load_data`=1. On a `mem_ack` edge it goes to WB for one cycle with `wrt_en`=1 and `load_data`=1, then to IDLE.
- 5 store: IDLE → MEM with `mem_req`=1, `mem_we`=1, `rd_addr1`=opr1, held until a `mem_ack` edge, then IDLE. There is no `wrt_en`.

Other opcodes:
- 9 halt: IDLE → HALT with `halted`=1. A `resume` edge returns to IDLE. `resume` outside HALT is ignored.
- 10..15: go to EXEC with no write or request, and set `illegal`.

Rules common to all states:
- `wrt_en` is high only in EXEC, for a writing opcode, or in WB.
- Address outputs and `load_data` hold their values through MEM and WB.
- All address outputs and `load_data` clear to 0 on return to IDLE.
- `mem_ack` while `mem_req` is low is ignored.
- `illegal` and `mem_err` clear only on reset.

## Timing
- Reset: every output is 0 except `instr_ready`=1; state is IDLE.
- Assertion of `rst_n` mid-operation drops `mem_req` and `wrt_en` asynchronously, with no completion of the instruction.
- An instruction accepted at edge N has its decode outputs valid during cycle N+1. `instr_ready` returns during cycle N+2, giving 1 instruction per 2 cycles for non-memory ops.
- Load with an ack sampled at edge M: the WB strobe is in cycle M+1 and `instr_ready` is high in M+2. A same-cycle ack (sampled at the first MEM edge) is legal.
- Store with an ack at edge M: `instr_ready` is high in M+1.
- `instr` must be held stable only on the accepting edge.

## Configuration
- `DECO_TIMEOUT_EN` defined:
  - An 8-bit counter runs in MEM and is cleared on entry.
  - If `mem_ack` has not been seen after `TIMEOUT` cycles in MEM, the block goes to IDLE, drops `mem_req`, sets `mem_err`, and never asserts `wrt_en` for that load.
  - An ack on the same edge the limit is reached wins: the access completes normally.
- `DECO_TIMEOUT_EN` undefined: MEM waits indefinitely, and `mem_err` is constant 0.

## Test plan
- Reset, then add with opr1=1, opr2=2 (RA_W=2) → cycle N+1 shows `rd_addr1`=1, `rd_addr2`=2, `wrt_addr`=1, `wrt_en`=1 for exactly one cycle; `instr_ready` is high in N+2.
- Load to r3 with `mem_ack` delayed 3 cycles → `mem_req` is high for 3 cycles, then one cycle of `wrt_en`=1, `load_data`=1, `wrt_addr`=3.
- Store r2 with `mem_ack` in the first MEM cycle → `mem_we`=1 and `rd_addr1`=2; no `wrt_en` at any point; ready two edges after accept.
- Halt, then offer copy r0←r1 → held off with `instr_ready`=0; a `resume` pulse leads to acceptance and `rd_addr1`=1, `wrt_addr`=0.
- Opcode 12 → `illegal`=1 and no `wrt_en`; `illegal` is still set after 10 more noops; reset clears it.
- With `DECO_TIMEOUT_EN` and TIMEOUT=4, a load with no ack → `mem_req` drops after 4 cycles and `mem_err`=1 with no write. Repeat with reset mid-MEM → all outputs 0 immediately.
